// File: rtl/vga_sync_generator.sv
// ----------------------------------------------------------------------------
// vga_sync_generator
// Tracks the vertical line count from the horizontal counter's line-start
// pulse. Produces registered VGA timing outputs with exactly one clock of
// latency from H_Count_Value.
//
// Ports
//   clk_25MHz         in   pixel clock
//   rst               in   asynchronous active-high reset
//   enable_V_Counter  in   line-start pulse (expected only while H == 0)
//   H_Count_Value     in   horizontal position, 16 bits
//   V_Count_Value     out  vertical line count 0..V_TOTAL-1
//   v_state           out  vertical phase: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK
//   hsync / vsync     out  sync pulses, active level H_POL / V_POL
//   video_on          out  high inside the visible area
//   pixel_x / pixel_y out  visible coordinates; zero outside the visible area
//   frame_start       out  one-clock strobe on pixel (0,0)
//   timing_error      out  sticky flag for inconsistent horizontal inputs
// ----------------------------------------------------------------------------
module vga_sync_generator #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter logic        H_POL     = 1'b0,
   parameter logic        V_POL     = 1'b0
) (
   input  logic        clk_25MHz,
   input  logic        rst,
   input  logic        enable_V_Counter,
   input  logic [15:0] H_Count_Value,
   output logic [15:0] V_Count_Value,
   output logic [1:0]  v_state,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        frame_start,
   output logic        timing_error
);

   localparam int unsigned CW      = 16;
   localparam int unsigned PW      = 10;
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_VISIBLE + H_FRONT);
   localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0] V_FRONT_LO   = CW'(V_VISIBLE);
   localparam logic [CW-1:0] V_SYNC_LO    = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0] V_BACK_LO    = CW'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FRONT  = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BACK   = 2'd3
   } v_state_e;

   logic [CW-1:0] v_count_q, v_count_d;
   v_state_e      v_state_q, v_state_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic [PW-1:0] pixel_x_q, pixel_x_d;
   logic [PW-1:0] pixel_y_q, pixel_y_d;
   logic          frame_start_q, frame_start_d;
   logic          timing_error_q, timing_error_d;

   // Next-state: effective line, phase decode and timing outputs from (H, L)
   always_comb begin
      v_count_d      = v_count_q;
      v_state_d      = ST_ACTIVE;
      hsync_d        = ~H_POL;
      vsync_d        = ~V_POL;
      video_on_d     = 1'b0;
      pixel_x_d      = '0;
      pixel_y_d      = '0;
      frame_start_d  = 1'b0;
      timing_error_d = timing_error_q;

      // An enable with H != 0 still advances the line; it only flags an error
      if (enable_V_Counter) begin
         v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + CW'(1);
      end

      if (v_count_d < V_FRONT_LO) begin
         v_state_d = ST_ACTIVE;
      end else if (v_count_d < V_SYNC_LO) begin
         v_state_d = ST_FRONT;
      end else if (v_count_d < V_BACK_LO) begin
         v_state_d = ST_SYNC;
      end else begin
         v_state_d = ST_BACK;
      end

      if ((H_Count_Value >= H_SYNC_FIRST) && (H_Count_Value <= H_SYNC_LAST)) begin
         hsync_d = H_POL;
      end
      if (v_state_d == ST_SYNC) begin
         vsync_d = V_POL;
      end

      // Full-width compare so out-of-range H never aliases into the visible area
      video_on_d = (H_Count_Value < CW'(H_VISIBLE)) && (v_state_d == ST_ACTIVE);
      if (video_on_d) begin
         pixel_x_d = H_Count_Value[PW-1:0];
         pixel_y_d = v_count_d[PW-1:0];
      end

      // Fires from position alone, so the first line after reset is covered too
      frame_start_d = (H_Count_Value == '0) && (v_count_d == '0);

      if ((enable_V_Counter && (H_Count_Value != '0)) ||
          (H_Count_Value >= CW'(H_TOTAL))) begin
         timing_error_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         v_count_q      <= '0;
         v_state_q      <= ST_ACTIVE;
         hsync_q        <= ~H_POL;
         vsync_q        <= ~V_POL;
         video_on_q     <= 1'b0;
         pixel_x_q      <= '0;
         pixel_y_q      <= '0;
         frame_start_q  <= 1'b0;
         timing_error_q <= 1'b0;
      end else begin
         v_count_q      <= v_count_d;
         v_state_q      <= v_state_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         video_on_q     <= video_on_d;
         pixel_x_q      <= pixel_x_d;
         pixel_y_q      <= pixel_y_d;
         frame_start_q  <= frame_start_d;
         timing_error_q <= timing_error_d;
      end
   end

   assign V_Count_Value = v_count_q;
   assign v_state       = v_state_q;
   assign hsync         = hsync_q;
   assign vsync         = vsync_q;
   assign video_on      = video_on_q;
   assign pixel_x       = pixel_x_q;
   assign pixel_y       = pixel_y_q;
   assign frame_start   = frame_start_q;
   assign timing_error  = timing_error_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_generator
// Directed and randomized stimulus for vga_sync_generator. A driver pushes
// the expected post-edge outputs into a queue; a monitor pops and compares
// one entry per clock.
// ----------------------------------------------------------------------------
module tb_vga_sync_generator;

   logic        clk_25MHz = 1'b0;
   logic        rst;
   logic        enable_V_Counter;
   logic [15:0] H_Count_Value;
   logic [15:0] V_Count_Value;
   logic [1:0]  v_state;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        frame_start;
   logic        timing_error;

   always #20 clk_25MHz = ~clk_25MHz;

   vga_sync_generator dut (
      .clk_25MHz        (clk_25MHz),
      .rst              (rst),
      .enable_V_Counter (enable_V_Counter),
      .H_Count_Value    (H_Count_Value),
      .V_Count_Value    (V_Count_Value),
      .v_state          (v_state),
      .hsync            (hsync),
      .vsync            (vsync),
      .video_on         (video_on),
      .pixel_x          (pixel_x),
      .pixel_y          (pixel_y),
      .frame_start      (frame_start),
      .timing_error     (timing_error)
   );

   typedef struct {
      int vc;
      int vs;
      int hs;
      int vsy;
      int vo;
      int px;
      int py;
      int fs;
      int te;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   m_line  = 0;
   int   m_err   = 0;
   int   exp_fs  = 0;
   int   seen_fs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: 800x525 raster, 640x480 visible, syncs at 656..751 / 490..491
   task automatic drive(input int h, input bit en, input bit r);
      exp_t e;
      int   l;
      @(negedge clk_25MHz);
      rst              = r;
      enable_V_Counter = en;
      H_Count_Value    = 16'(h);
      if (r) begin
         m_line = 0;
         m_err  = 0;
         e = '{vc: 0, vs: 0, hs: 1, vsy: 1, vo: 0, px: 0, py: 0, fs: 0, te: 0};
      end else begin
         l = en ? (m_line + 1) % 525 : m_line;
         if ((en && h != 0) || h >= 800) m_err = 1;
         e.vc  = l;
         e.vs  = (l < 480) ? 0 : (l < 490) ? 1 : (l < 492) ? 2 : 3;
         e.hs  = (h >= 656 && h <= 751) ? 0 : 1;
         e.vsy = (l == 490 || l == 491) ? 0 : 1;
         e.vo  = (h < 640 && l < 480) ? 1 : 0;
         e.px  = e.vo ? h : 0;
         e.py  = e.vo ? l : 0;
         e.fs  = (h == 0 && l == 0) ? 1 : 0;
         e.te  = m_err;
         m_line = l;
         if (e.fs == 1) exp_fs++;
      end
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry per clock, sampled just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_25MHz);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("V_Count_Value", 32'(V_Count_Value), 32'(e.vc));
            chk("v_state",       32'(v_state),       32'(e.vs));
            chk("hsync",         32'(hsync),         32'(e.hs));
            chk("vsync",         32'(vsync),         32'(e.vsy));
            chk("video_on",      32'(video_on),      32'(e.vo));
            chk("pixel_x",       32'(pixel_x),       32'(e.px));
            chk("pixel_y",       32'(pixel_y),       32'(e.py));
            chk("frame_start",   32'(frame_start),   32'(e.fs));
            chk("timing_error",  32'(timing_error),  32'(e.te));
            if (frame_start === 1'b1) seen_fs++;
         end
      end
   end

   initial begin
      int h;
      rst              = 1'b1;
      enable_V_Counter = 1'b0;
      H_Count_Value    = 16'd0;

      repeat (3) drive(0, 1'b0, 1'b1);

      // Ideal horizontal counter, two lines; no enable on the first line after reset
      for (int n = 0; n < 1600; n++) drive(n % 800, (n % 800 == 0) && (n > 0), 1'b0);

      // Two full frames stepped one line per clock at H=0, crossing the 524->0 wrap twice
      for (int n = 0; n < 1050; n++) drive(0, 1'b1, 1'b0);

      // Line 100 with a full horizontal sweep
      while (m_line != 99) drive(0, 1'b1, 1'b0);
      for (int x = 0; x < 800; x++) drive(x, x == 0, 1'b0);

      // Error injection, then a clean frame during which the flag must stay set
      drive(37, 1'b1, 1'b0);
      drive(800, 1'b0, 1'b0);
      for (int n = 0; n < 525; n++) drive(0, 1'b1, 1'b0);

      // Reset mid-frame at V=300, H=400
      while (m_line != 300) drive(0, 1'b1, 1'b0);
      drive(400, 1'b0, 1'b0);
      repeat (3) drive(400, 1'b0, 1'b1);
      drive(0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0);

      // Random legal inputs: timing_error must remain clear
      for (int n = 0; n < 3000; n++) begin
         h = int'($urandom_range(0, 799));
         drive(h, h == 0, 1'b0);
      end

      // Random inputs including out-of-range H and misplaced enables
      for (int n = 0; n < 2000; n++) begin
         h = int'($urandom_range(0, 1023));
         drive(h, $urandom_range(0, 7) == 0, 1'b0);
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_25MHz);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("frame_start_count",  32'(seen_fs),      32'(exp_fs));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
